dtw_result_collector: RTL and testbench
=======================================

Name: dtw_result_collector

Overview:
Downstream stage of the DTW processor. Consumes the processor's strobed outputs (distance, template index, frame length) and tracks the minimum distance and its template over one comparison frame. At frame close it classifies the frame against a threshold and presents one result word on a valid/ready handshake to the host/readout logic. Also counts frames, rejected samples and dropped results.

Parameters:
IDX_W, 8, width of template index and class code
THRESH, 32'sd1000, maximum accepted distance; a min distance above this gives NO_MATCH
CNT_W, 16, width of the saturating status counters
NO_MATCH, {IDX_W{1'b1}}, class code for no valid match

Ports:
clk  in  1  system clock
rst_geral  in  1  asynchronous, active-high reset
frame_clr  in  1  sync clear of the accumulator; driven from the same pulse that restarts the DTW processor
dist_in  in  32  signed distance (DTW out0)
idx_in  in  32  template index (DTW out1); only bits [IDX_W-1:0] are used
len_in  in  32  frame length (DTW out2); only bits [6:0] are used
out_en  in  3  DTW output strobes: [0] distance valid, [1] index valid, [2] frame close
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_class  out  IDX_W  winning template index, or NO_MATCH
res_dist  out  32  minimum distance of the frame
res_len  out  7  frame length
frame_cnt  out  CNT_W  frames closed (saturating)
neg_cnt  out  CNT_W  negative distances rejected (saturating)
ovr_cnt  out  CNT_W  results dropped by overrun (saturating)

Behaviour:
- Reset (rst_geral): all outputs 0, except res_class = NO_MATCH. Internal state: state=COLLECT, min_dist=32'h7FFFFFFF, have_min=0, cur_idx=0.
- Accumulator updates, applied in this order when several strobes share a cycle:
  1. out_en[1]: cur_idx <= idx_in[IDX_W-1:0].
  2. out_en[0]: compare dist_in, paired with the index latched in step 1 of the same cycle if present, else the held cur_idx.
     - dist_in < 0: reject, neg_cnt += 1, no compare.
     - else if !have_min or dist_in < min_dist (strict signed compare): min_dist <= dist_in, min_idx <= index, have_min <= 1.
     - Ties keep the earlier template.
  3. out_en[2]: close the frame. The compare uses the values after steps 1–2 of the same cycle.
- Close:
  - Build the result: class = (have_min && min_dist <= THRESH) ? min_idx : NO_MATCH; dist = have_min ? min_dist : 32'h7FFFFFFF; len = len_in[6:0].
  - frame_cnt += 1.
  - Accumulator returns to its reset values on the next edge.
- Output register, single entry:
  - If res_valid=0, or res_valid && res_ready in the close cycle: load the result, res_valid=1 on the next edge. Latency is 1 cycle from the out_en[2] edge.
  - If res_valid=1 && res_ready=0: drop the new result, ovr_cnt += 1, held result unchanged.
- Handshake:
  - res_valid && res_ready at an edge consumes the result; res_valid drops next cycle unless a close reloads it in the same cycle.
  - res_* stay stable while res_valid=1 && !res_ready.
- FSM states:
  - COLLECT: normal accumulation.
  - HOLD: entered on close when the output register is occupied and not being accepted. Accumulation continues; closes in HOLD count as overruns.
  - HOLD→COLLECT on acceptance.
  - The FSM only qualifies overrun accounting; accumulation never stalls.
- frame_clr: resets the accumulator only (not the output register or counters) and has priority over same-cycle out_en[0]/[1]. An out_en[2] in the same cycle closes an empty frame (NO_MATCH, dist 7FFFFFFF).
- Counters saturate at all-ones and do not wrap.
- Reset mid-frame or mid-handshake discards everything.

Decomposition:
- Shared package dtw_pkg: NO_MATCH, DIST_MAX (32'h7FFFFFFF), the out_en bit positions (EN_DIST=0, EN_IDX=1, EN_CLOSE=2), and the FSM state enum.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated three times.

Test Plan:
- idx 3/dist 500, idx 5/dist 200, idx 7/dist 200, then close with len 40 -> one cycle later res_valid=1, class 5, dist 200, len 40; frame_cnt=1.
- Single distance 1500 (above THRESH 1000), then close -> class NO_MATCH, res_dist 1500.
- Close with no distances seen -> NO_MATCH, dist 32'h7FFFFFFF; a same-cycle out_en=3'b111 (idx 2, dist 10) -> class 2, dist 10.
- res_ready=0 and two closes -> first result held unchanged, ovr_cnt=1; res_ready=1 -> valid drops; next close loads normally.
- dist_in=-4 strobed -> neg_cnt=1, min unchanged; frame_clr together with out_en[0] dist 1 -> distance ignored.
- Assert rst_geral asynchronously while res_valid=1 mid-frame -> all outputs 0, class NO_MATCH immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW result collection path: strobe bit
// positions, the empty-frame distance and the collector state encoding.
package dtw_pkg;

    localparam int unsigned EN_DIST  = 0;
    localparam int unsigned EN_IDX   = 1;
    localparam int unsigned EN_CLOSE = 2;

    localparam logic signed [31:0] DIST_MAX = 32'sh7FFF_FFFF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } col_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for status reporting; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dtw_result_collector.sv
// Tracks the minimum DTW distance per frame, classifies it at frame close
// and offers one result word on a valid/ready port with status counters.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | normal accumulation, output register free or draining
// HOLD    | a close found the output register blocked; waits for accept
module dtw_result_collector
    import dtw_pkg::*;
#(
    parameter int                IDX_W    = 8,
    parameter logic signed [31:0] THRESH  = 32'sd1000,
    parameter int                CNT_W    = 16,
    parameter logic [IDX_W-1:0]  NO_MATCH = {IDX_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_geral,
    input  logic             frame_clr,
    input  logic [31:0]      dist_in,
    input  logic [31:0]      idx_in,
    input  logic [31:0]      len_in,
    input  logic [2:0]       out_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_class,
    output logic [31:0]      res_dist,
    output logic [6:0]       res_len,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] neg_cnt,
    output logic [CNT_W-1:0] ovr_cnt
);

    col_state_e state_q, state_d;

    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]   min_idx_q, min_idx_d;
    logic signed [31:0] min_dist_q, min_dist_d;
    logic               have_min_q, have_min_d;

    logic               res_valid_q, res_valid_d;
    logic [IDX_W-1:0]   res_class_q, res_class_d;
    logic [31:0]        res_dist_q, res_dist_d;
    logic [6:0]         res_len_q, res_len_d;

    logic signed [31:0] dist_s;
    logic [IDX_W-1:0]   cur_idx_a, min_idx_a;
    logic signed [31:0] min_dist_a;
    logic               have_min_a;
    logic               neg_inc;
    logic               close;
    logic               load;
    logic               accept;
    logic               ovr_inc;
    logic [IDX_W-1:0]   cls_new;
    logic signed [31:0] dist_new;

    logic unused_bits;
    assign unused_bits = ^{idx_in[31:IDX_W], len_in[31:7]};

    assign dist_s = $signed(dist_in);
    assign close  = out_en[EN_CLOSE];
    assign accept = res_valid_q && res_ready;
    assign load   = close && (!res_valid_q || res_ready);

    // Accumulator after this cycle's strobes; the close sees these values.
    always_comb begin
        cur_idx_a  = cur_idx_q;
        min_idx_a  = min_idx_q;
        min_dist_a = min_dist_q;
        have_min_a = have_min_q;
        neg_inc    = 1'b0;
        if (frame_clr) begin
            cur_idx_a  = '0;
            min_idx_a  = '0;
            min_dist_a = DIST_MAX;
            have_min_a = 1'b0;
        end else begin
            if (out_en[EN_IDX]) begin
                cur_idx_a = idx_in[IDX_W-1:0];
            end
            if (out_en[EN_DIST]) begin
                if (dist_s < 0) begin
                    neg_inc = 1'b1;
                end else if (!have_min_q || (dist_s < min_dist_q)) begin
                    min_dist_a = dist_s;
                    min_idx_a  = cur_idx_a;
                    have_min_a = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cls_new  = (have_min_a && (min_dist_a <= THRESH)) ? min_idx_a : NO_MATCH;
        dist_new = have_min_a ? min_dist_a : DIST_MAX;
        if (close) begin
            cur_idx_d  = '0;
            min_idx_d  = '0;
            min_dist_d = DIST_MAX;
            have_min_d = 1'b0;
        end else begin
            cur_idx_d  = cur_idx_a;
            min_idx_d  = min_idx_a;
            min_dist_d = min_dist_a;
            have_min_d = have_min_a;
        end
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_dist_d  = res_dist_q;
        res_len_d   = res_len_q;
        if (load) begin
            res_valid_d = 1'b1;
            res_class_d = cls_new;
            res_dist_d  = dist_new;
            res_len_d   = len_in[6:0];
        end else if (accept) begin
            res_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_inc = 1'b0;
        case (state_q)
            COLLECT: begin
                if (close && res_valid_q && !res_ready) begin
                    ovr_inc = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = COLLECT;
                end else if (close) begin
                    ovr_inc = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst_geral) begin
        if (rst_geral) begin
            state_q     <= COLLECT;
            cur_idx_q   <= '0;
            min_idx_q   <= '0;
            min_dist_q  <= DIST_MAX;
            have_min_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= NO_MATCH;
            res_dist_q  <= '0;
            res_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            min_idx_q   <= min_idx_d;
            min_dist_q  <= min_dist_d;
            have_min_q  <= have_min_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_dist_q  <= res_dist_d;
            res_len_q   <= res_len_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk_i (clk),
        .rst_i (rst_geral),
        .inc_i (close),
        .clr_i (1'b0),
        .cnt_o (frame_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_neg_cnt (
        .clk_i (clk),
        .rst_i (rst_geral),
        .inc_i (neg_inc),
        .clr_i (1'b0),
        .cnt_o (neg_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ovr_cnt (
        .clk_i (clk),
        .rst_i (rst_geral),
        .inc_i (ovr_inc),
        .clr_i (1'b0),
        .cnt_o (ovr_cnt)
    );

    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_dist  = res_dist_q;
    assign res_len   = res_len_q;

endmodule

// File: tb/tb_dtw_result_collector.sv
// Bench for dtw_result_collector: directed scenarios then random traffic,
// checked against a frame-list reference model.
module tb_dtw_result_collector;

    logic        clk = 1'b0;
    logic        rst_geral;
    logic        frame_clr;
    logic [31:0] dist_in;
    logic [31:0] idx_in;
    logic [31:0] len_in;
    logic [2:0]  out_en;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_class;
    logic [31:0] res_dist;
    logic [6:0]  res_len;
    logic [15:0] frame_cnt;
    logic [15:0] neg_cnt;
    logic [15:0] ovr_cnt;

    always #5 clk = ~clk;

    dtw_result_collector dut (
        .clk       (clk),
        .rst_geral (rst_geral),
        .frame_clr (frame_clr),
        .dist_in   (dist_in),
        .idx_in    (idx_in),
        .len_in    (len_in),
        .out_en    (out_en),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_dist  (res_dist),
        .res_len   (res_len),
        .frame_cnt (frame_cnt),
        .neg_cnt   (neg_cnt),
        .ovr_cnt   (ovr_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the frame is a list of (index, distance) pairs.
    int         q_dist[$];
    logic [7:0] q_idx[$];
    logic [7:0] m_cur;
    logic       m_valid;
    logic [7:0] m_class;
    logic [31:0] m_rdist;
    logic [6:0] m_len;
    int         m_frame, m_neg, m_ovr;

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        q_dist.delete();
        q_idx.delete();
        m_cur   = 8'd0;
        m_valid = 1'b0;
        m_class = 8'hFF;
        m_rdist = 32'd0;
        m_len   = 7'd0;
        m_frame = 0;
        m_neg   = 0;
        m_ovr   = 0;
    endtask

    task automatic model_step(input logic [2:0] en, input logic fc, input int d,
                              input int ix, input int ln, input logic rdy);
        int best;
        if (fc) begin
            q_dist.delete();
            q_idx.delete();
            m_cur = 8'd0;
        end else begin
            if (en[1]) m_cur = ix[7:0];
            if (en[0]) begin
                if (d < 0) m_neg = sat_inc(m_neg);
                else begin
                    q_dist.push_back(d);
                    q_idx.push_back(m_cur);
                end
            end
        end
        if (en[2]) begin
            best = -1;
            foreach (q_dist[i])
                if (best < 0 || q_dist[i] < q_dist[best]) best = i;
            m_frame = sat_inc(m_frame);
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_class = (best >= 0 && q_dist[best] <= 1000) ? q_idx[best] : 8'hFF;
                m_rdist = (best >= 0) ? q_dist[best] : 32'h7FFF_FFFF;
                m_len   = ln[6:0];
            end else begin
                m_ovr = sat_inc(m_ovr);
            end
            q_dist.delete();
            q_idx.delete();
            m_cur = 8'd0;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        check("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
        check("res_class", {24'd0, res_class}, {24'd0, m_class});
        check("res_dist",  res_dist, m_rdist);
        check("res_len",   {25'd0, res_len}, {25'd0, m_len});
        check("frame_cnt", {16'd0, frame_cnt}, m_frame);
        check("neg_cnt",   {16'd0, neg_cnt}, m_neg);
        check("ovr_cnt",   {16'd0, ovr_cnt}, m_ovr);
    endtask

    task automatic step(input logic [2:0] en, input logic fc, input int d,
                        input int ix, input int ln, input logic rdy);
        out_en    = en;
        frame_clr = fc;
        dist_in   = d;
        idx_in    = ix;
        len_in    = ln;
        res_ready = rdy;
        @(posedge clk);
        #1;
        model_step(en, fc, d, ix, ln, rdy);
        check_all();
    endtask

    initial begin
        int d;
        rst_geral = 1'b1;
        frame_clr = 1'b0;
        dist_in   = '0;
        idx_in    = '0;
        len_in    = '0;
        out_en    = '0;
        res_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_geral = 1'b0;

        // Minimum with a tie: index 5 must win over 7.
        step(3'b011, 0, 500, 3, 0, 1);
        step(3'b011, 0, 200, 5, 0, 1);
        step(3'b011, 0, 200, 7, 0, 1);
        step(3'b100, 0, 0, 0, 40, 1);
        step(3'b000, 0, 0, 0, 0, 1);

        // Above threshold.
        step(3'b011, 0, 1500, 9, 0, 1);
        step(3'b100, 0, 0, 0, 12, 1);
        step(3'b000, 0, 0, 0, 0, 1);

        // Empty frame, then all strobes together while accepting.
        step(3'b100, 0, 0, 0, 3, 0);
        step(3'b111, 0, 10, 2, 5, 1);
        step(3'b000, 0, 0, 0, 0, 1);

        // Overrun while blocked, then drain and reload.
        step(3'b011, 0, 300, 4, 0, 0);
        step(3'b100, 0, 0, 0, 20, 0);
        step(3'b011, 0, 100, 6, 0, 0);
        step(3'b100, 0, 0, 0, 21, 0);
        step(3'b000, 0, 0, 0, 0, 0);
        step(3'b000, 0, 0, 0, 0, 1);
        step(3'b011, 0, 50, 1, 0, 0);
        step(3'b100, 0, 0, 0, 22, 0);
        step(3'b000, 0, 0, 0, 0, 1);

        // Negative reject and frame_clr priority.
        step(3'b011, 0, 700, 8, 0, 1);
        step(3'b001, 0, -4, 0, 0, 1);
        step(3'b011, 1, 1, 3, 0, 1);
        step(3'b100, 0, 0, 0, 9, 1);
        step(3'b000, 0, 0, 0, 0, 1);

        // Asynchronous reset while holding a result mid-frame.
        step(3'b011, 0, 70, 3, 0, 0);
        step(3'b100, 0, 0, 0, 30, 0);
        step(3'b011, 0, 10, 2, 0, 0);
        out_en    = '0;
        res_ready = 1'b0;
        #2;
        rst_geral = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_geral = 1'b0;

        for (int n = 0; n < 600; n++) begin
            case ($urandom % 8)
                0: d = -int'($urandom_range(1, 1000));
                1: d = int'($urandom);
                2: d = 200;
                default: d = int'($urandom_range(0, 2000));
            endcase
            step({($urandom % 6) == 0, 1'($urandom % 2), 1'($urandom % 2)},
                 ($urandom % 25) == 0, d, int'($urandom), int'($urandom),
                 ($urandom % 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
